hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter PIPE_DEPTH, default 3, giving the number of tracked stages after decode (EXE=1, MEM=2, WB=3); the legal range is 2..7.
REQ-002 The block SHALL have parameter LOAD_READY_STAGE, default 2, giving the first stage index from which a load result can be forwarded; the legal range is 1..PIPE_DEPTH.
REQ-003 The block SHALL have parameter REG_ADDR_WIDTH, default 5, giving the register address width.
REQ-004 The block SHALL derive localparam FWD_WIDTH = clog2(PIPE_DEPTH+1), which is 2 at the defaults.
REQ-005 The ports SHALL be as follows, clock and reset first:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- decodeValid  in  1  the decode stage holds a real instruction.
- decodeRs  in  REG_ADDR_WIDTH  source register rs.
- decodeRt  in  REG_ADDR_WIDTH  source register rt.
- decodeUsesRs  in  1  the instruction reads rs.
- decodeUsesRt  in  1  the instruction reads rt.
- decodeWritesRegister  in  1  the instruction writes a register (WREG).
- decodeWriteRegister  in  REG_ADDR_WIDTH  destination register (rt or rd, already selected).
- decodeIsLoad  in  1  the instruction is a load (M2REG).
- flush  in  1  squash the decode instruction (taken branch or jump).
- shouldStall  out  1  hold PC and the IF/ID register (WPCIR inverse).
- registerRsForwardControl  out  FWD_WIDTH  rs source select: 0 = register file, k = stage-k result bus.
- registerRtForwardControl  out  FWD_WIDTH  rt source select, same encoding.
- stallCount  out  16  number of stall cycles since reset.

Function
REQ-006 The block SHALL hold a scoreboard of PIPE_DEPTH entries, indexed 1..PIPE_DEPTH; each entry stores valid, dest and isLoad.
REQ-007 On every clock edge the entries SHALL shift: entry k+1 takes entry k, and entry PIPE_DEPTH is discarded (retired into the register file).
REQ-008 Entry 1 SHALL load {1, decodeWriteRegister, decodeIsLoad} when decodeValid && decodeWritesRegister && !shouldStall && !flush, and SHALL load a bubble (valid=0) otherwise.
REQ-009 An entry SHALL match source s when it is valid, dest==s, s!=0, and the corresponding decodeUses* input is 1; register 0 never matches.
REQ-010 For each source, only the lowest-index (youngest) matching entry SHALL be considered.
REQ-011 The forward control SHALL be k when the youngest match is at stage k and the value is ready, meaning !isLoad, or isLoad with k >= LOAD_READY_STAGE.
REQ-012 The forward control SHALL be 0 when there is no match.
REQ-013 When the youngest match for either source is not ready, the block SHALL assert shouldStall and SHALL drive both forward controls to 0.
REQ-014 shouldStall SHALL be 0 whenever flush=1 or decodeValid=0, regardless of scoreboard contents.
REQ-015 The forward controls SHALL be 0 whenever decodeValid=0.
REQ-016 shouldStall and the forward controls SHALL be combinational from the current scoreboard state and the decode inputs, with zero-cycle latency.
REQ-017 A stall SHALL last until the blocking entry reaches a ready stage; for a load at stage j, this is LOAD_READY_STAGE - j cycles.
REQ-018 stallCount SHALL increment by 1 on each edge where shouldStall=1, and SHALL saturate at 0xFFFF without wrapping.
REQ-019 When flush and a hazard occur together, flush SHALL win: no stall is asserted, a bubble is inserted, and stallCount is unchanged.

Reset
REQ-020 While reset=1 at a clock edge, all entries SHALL become invalid and stallCount SHALL become 0.
REQ-021 Reset SHALL take priority over any shift, issue or flush in the same cycle.
REQ-022 After reset, shouldStall=0 and both forward controls=0 SHALL hold until a valid writer is issued.
REQ-023 Reset asserted mid-stall SHALL clear the stall by the next cycle.

Verification
REQ-024 ALU back-to-back, defaults: issue add $3; next cycle decode reads rs=$3 -> rsForward=1, no stall; one cycle later another reader of $3 -> rsForward=2.
REQ-025 Load-use, defaults: issue lw $4; next cycle decode reads rt=$4 -> shouldStall=1 for exactly 1 cycle, then rtForward=2, and stallCount=1.
REQ-026 Youngest wins: issue add $5, then sub $5; decode reads $5 -> rsForward=1, not 2.
REQ-027 Register 0 and flush: lw $0 followed by a reader of $0 -> no stall and forward=0; lw $6 followed by a reader of $6 with flush=1 -> no stall, and entry 1 is a bubble on the next cycle.
REQ-028 Parametric, PIPE_DEPTH=5 and LOAD_READY_STAGE=4: lw $7 followed by a reader of $7 -> 3 stall cycles, then forward=4; a writer aged past stage 5 -> forward=0.
REQ-029 Saturation and reset: hold a permanent hazard for 70000 cycles -> stallCount=0xFFFF; then assert reset for 1 cycle -> stallCount=0, shouldStall=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Groups the decode-stage request and the hazard-unit response of
// hazard_scoreboard.
//
// Handshake: decodeValid says the decode stage holds a real instruction.
// shouldStall acts as the inverse of ready. The instruction is accepted into
// the pipeline on a rising edge only when decodeValid=1, shouldStall=0 and
// flush=0. While shouldStall=1 the master must hold the decode fields stable.
//
// Signals (master -> slave):
//   decodeValid, decodeRs, decodeRt, decodeUsesRs, decodeUsesRt,
//   decodeWritesRegister, decodeWriteRegister, decodeIsLoad, flush
// Signals (slave -> master):
//   shouldStall, registerRsForwardControl, registerRtForwardControl,
//   stallCount
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
   parameter int PIPE_DEPTH     = 3,
   parameter int REG_ADDR_WIDTH = 5
);
   localparam int FWD_WIDTH = $clog2(PIPE_DEPTH + 1);

   logic                      decodeValid;
   logic [REG_ADDR_WIDTH-1:0] decodeRs;
   logic [REG_ADDR_WIDTH-1:0] decodeRt;
   logic                      decodeUsesRs;
   logic                      decodeUsesRt;
   logic                      decodeWritesRegister;
   logic [REG_ADDR_WIDTH-1:0] decodeWriteRegister;
   logic                      decodeIsLoad;
   logic                      flush;
   logic                      shouldStall;
   logic [FWD_WIDTH-1:0]      registerRsForwardControl;
   logic [FWD_WIDTH-1:0]      registerRtForwardControl;
   logic [15:0]               stallCount;

   modport master (
      output decodeValid, decodeRs, decodeRt, decodeUsesRs, decodeUsesRt,
             decodeWritesRegister, decodeWriteRegister, decodeIsLoad, flush,
      input  shouldStall, registerRsForwardControl, registerRtForwardControl,
             stallCount
   );

   modport slave (
      input  decodeValid, decodeRs, decodeRt, decodeUsesRs, decodeUsesRt,
             decodeWritesRegister, decodeWriteRegister, decodeIsLoad, flush,
      output shouldStall, registerRsForwardControl, registerRtForwardControl,
             stallCount
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks the destination registers of the instructions in flight after
// decode and decides, for the instruction in decode, whether each source can
// be forwarded from a later stage or whether decode must stall for a load.
//
// Ports:
//   clock  - sole clock, rising edge
//   reset  - synchronous, active-high; clears the scoreboard and stallCount
//   bus    - hazard_scoreboard_if.slave: decode request in, stall/forward
//            selects and the saturating stall counter out
//
// Forward select encoding: 0 = register file, k = result bus of stage k.
// Legal parameters: PIPE_DEPTH 2..7, LOAD_READY_STAGE 1..PIPE_DEPTH.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int PIPE_DEPTH       = 3,
   parameter int LOAD_READY_STAGE = 2,
   parameter int REG_ADDR_WIDTH   = 5
) (
   input  logic               clock,
   input  logic               reset,
   hazard_scoreboard_if.slave bus
);
   localparam int FWD_WIDTH = $clog2(PIPE_DEPTH + 1);

   // Entry k describes the instruction currently in stage k (1 = EXE).
   logic [PIPE_DEPTH:1]       r_valid;
   logic [PIPE_DEPTH:1]       r_is_load;
   logic [REG_ADDR_WIDTH-1:0] r_dest [1:PIPE_DEPTH];
   logic [15:0]               r_stall_count;

   logic                 w_rs_hit;
   logic                 w_rs_ready;
   logic [FWD_WIDTH-1:0] w_rs_stage;
   logic                 w_rt_hit;
   logic                 w_rt_ready;
   logic [FWD_WIDTH-1:0] w_rt_stage;
   logic                 w_hazard;
   logic                 w_stall;
   logic                 w_issue;

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      w_rs_hit   = 1'b0;
      w_rs_ready = 1'b0;
      w_rs_stage = '0;
      w_rt_hit   = 1'b0;
      w_rt_ready = 1'b0;
      w_rt_stage = '0;
      for (int k = PIPE_DEPTH; k >= 1; k--) begin
         if (r_valid[k] && bus.decodeUsesRs && (bus.decodeRs != '0) &&
             (r_dest[k] == bus.decodeRs)) begin
            w_rs_hit   = 1'b1;
            w_rs_stage = FWD_WIDTH'(k);
            w_rs_ready = !r_is_load[k] || (k >= LOAD_READY_STAGE);
         end
         if (r_valid[k] && bus.decodeUsesRt && (bus.decodeRt != '0) &&
             (r_dest[k] == bus.decodeRt)) begin
            w_rt_hit   = 1'b1;
            w_rt_stage = FWD_WIDTH'(k);
            w_rt_ready = !r_is_load[k] || (k >= LOAD_READY_STAGE);
         end
      end
   end

   assign w_hazard = (w_rs_hit && !w_rs_ready) || (w_rt_hit && !w_rt_ready);
   // Flush squashes the decode instruction, so it never needs to wait.
   assign w_stall  = bus.decodeValid && !bus.flush && w_hazard;
   assign w_issue  = bus.decodeValid && bus.decodeWritesRegister &&
                     !w_stall && !bus.flush;

   always_comb begin
      bus.registerRsForwardControl = '0;
      bus.registerRtForwardControl = '0;
      if (bus.decodeValid && !w_hazard) begin
         if (w_rs_hit) bus.registerRsForwardControl = w_rs_stage;
         if (w_rt_hit) bus.registerRtForwardControl = w_rt_stage;
      end
   end

   assign bus.shouldStall = w_stall;
   assign bus.stallCount  = r_stall_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid       <= '0;
         r_is_load     <= '0;
         r_stall_count <= '0;
         for (int k = 1; k <= PIPE_DEPTH; k++) r_dest[k] <= '0;
      end else begin
         for (int k = PIPE_DEPTH; k >= 2; k--) begin
            r_valid[k]   <= r_valid[k-1];
            r_is_load[k] <= r_is_load[k-1];
            r_dest[k]    <= r_dest[k-1];
         end
         // A stalled or flushed decode enters the pipe as a bubble.
         r_valid[1]   <= w_issue;
         r_is_load[1] <= w_issue && bus.decodeIsLoad;
         r_dest[1]    <= w_issue ? bus.decodeWriteRegister : '0;
         if (w_stall && (r_stall_count != 16'hFFFF))
            r_stall_count <= r_stall_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.PIPE_DEPTH(3), .REG_ADDR_WIDTH(5)) bus_a ();
   hazard_scoreboard_if #(.PIPE_DEPTH(5), .REG_ADDR_WIDTH(5)) bus_b ();
   hazard_scoreboard_if #(.PIPE_DEPTH(7), .REG_ADDR_WIDTH(5)) bus_c ();

   hazard_scoreboard #(.PIPE_DEPTH(3), .LOAD_READY_STAGE(2), .REG_ADDR_WIDTH(5))
      dut_a (.clock(clk), .reset(rst), .bus(bus_a));
   hazard_scoreboard #(.PIPE_DEPTH(5), .LOAD_READY_STAGE(4), .REG_ADDR_WIDTH(5))
      dut_b (.clock(clk), .reset(rst), .bus(bus_b));
   hazard_scoreboard #(.PIPE_DEPTH(7), .LOAD_READY_STAGE(7), .REG_ADDR_WIDTH(5))
      dut_c (.clock(clk), .reset(rst), .bus(bus_c));

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic drive_a(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic wr,
                          input logic [4:0] wd, input logic ld, input logic fl);
      bus_a.decodeValid = v;  bus_a.decodeRs = rs; bus_a.decodeUsesRs = urs;
      bus_a.decodeRt = rt;    bus_a.decodeUsesRt = urt;
      bus_a.decodeWritesRegister = wr; bus_a.decodeWriteRegister = wd;
      bus_a.decodeIsLoad = ld; bus_a.flush = fl;
      #1;
   endtask

   task automatic drive_b(input logic v, input logic [4:0] rs, input logic urs,
                          input logic wr, input logic [4:0] wd, input logic ld);
      bus_b.decodeValid = v;  bus_b.decodeRs = rs; bus_b.decodeUsesRs = urs;
      bus_b.decodeRt = 5'd0;  bus_b.decodeUsesRt = 1'b0;
      bus_b.decodeWritesRegister = wr; bus_b.decodeWriteRegister = wd;
      bus_b.decodeIsLoad = ld; bus_b.flush = 1'b0;
      #1;
   endtask

   task automatic idle_all();
      drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0);
      bus_c.decodeValid = 1'b0; bus_c.decodeRs = 5'd0; bus_c.decodeUsesRs = 1'b0;
      bus_c.decodeRt = 5'd0; bus_c.decodeUsesRt = 1'b0;
      bus_c.decodeWritesRegister = 1'b0; bus_c.decodeWriteRegister = 5'd0;
      bus_c.decodeIsLoad = 1'b0; bus_c.flush = 1'b0;
      #1;
   endtask

   // Scenario tasks
   task automatic test_reset();
      idle_all();
      pulse_reset();
      drive_a(1, 5'd3, 1, 5'd4, 1, 0, 0, 0, 0);
      n_checks++; if (bus_a.shouldStall !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", bus_a.shouldStall); else n_pass++;
      n_checks++; if (bus_a.registerRsForwardControl !== 2'd0) $display("FAIL reset_rsfwd: got %0d expected 0", bus_a.registerRsForwardControl); else n_pass++;
      n_checks++; if (bus_a.registerRtForwardControl !== 2'd0) $display("FAIL reset_rtfwd: got %0d expected 0", bus_a.registerRtForwardControl); else n_pass++;
      n_checks++; if (bus_a.stallCount !== 16'd0) $display("FAIL reset_count: got %0d expected 0", bus_a.stallCount); else n_pass++;
   endtask

   task automatic test_alu_back_to_back();
      pulse_reset();
      drive_a(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);       // add $3,$1,$2
      n_checks++; if (bus_a.shouldStall !== 1'b0) $display("FAIL alu_issue_stall: got %0b expected 0", bus_a.shouldStall); else n_pass++;
      step();
      drive_a(1, 5'd3, 1, 5'd0, 1, 1, 5'd8, 0, 0);       // add $8,$3,$0
      n_checks++; if (bus_a.registerRsForwardControl !== 2'd1) $display("FAIL alu_rsfwd1: got %0d expected 1", bus_a.registerRsForwardControl); else n_pass++;
      n_checks++; if (bus_a.registerRtForwardControl !== 2'd0) $display("FAIL alu_rtfwd_r0: got %0d expected 0", bus_a.registerRtForwardControl); else n_pass++;
      n_checks++; if (bus_a.shouldStall !== 1'b0) $display("FAIL alu_nostall: got %0b expected 0", bus_a.shouldStall); else n_pass++;
      step();
      drive_a(1, 5'd3, 1, 5'd9, 1, 0, 5'd0, 0, 0);       // sw $9,0($3)
      n_checks++; if (bus_a.registerRsForwardControl !== 2'd2) $display("FAIL alu_rsfwd2: got %0d expected 2", bus_a.registerRsForwardControl); else n_pass++;
      step();
      idle_all();
   endtask

   task automatic test_load_use();
      pulse_reset();
      drive_a(1, 5'd1, 1, 5'd0, 0, 1, 5'd4, 1, 0);       // lw $4,0($1)
      n_checks++; if (bus_a.shouldStall !== 1'b0) $display("FAIL lu_issue_stall: got %0b expected 0", bus_a.shouldStall); else n_pass++;
      step();
      drive_a(1, 5'd2, 1, 5'd4, 1, 1, 5'd9, 0, 0);       // add $9,$2,$4
      n_checks++; if (bus_a.shouldStall !== 1'b1) $display("FAIL lu_stall: got %0b expected 1", bus_a.shouldStall); else n_pass++;
      n_checks++; if (bus_a.registerRtForwardControl !== 2'd0) $display("FAIL lu_rtfwd_stall: got %0d expected 0", bus_a.registerRtForwardControl); else n_pass++;
      step();
      n_checks++; if (bus_a.shouldStall !== 1'b0) $display("FAIL lu_stall_end: got %0b expected 0", bus_a.shouldStall); else n_pass++;
      n_checks++; if (bus_a.registerRtForwardControl !== 2'd2) $display("FAIL lu_rtfwd: got %0d expected 2", bus_a.registerRtForwardControl); else n_pass++;
      n_checks++; if (bus_a.stallCount !== 16'd1) $display("FAIL lu_count: got %0d expected 1", bus_a.stallCount); else n_pass++;
      step();
      idle_all();
      step();
      n_checks++; if (bus_a.stallCount !== 16'd1) $display("FAIL lu_count_hold: got %0d expected 1", bus_a.stallCount); else n_pass++;
   endtask

   task automatic test_youngest();
      pulse_reset();
      drive_a(1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 0); step();  // add $5
      drive_a(1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 0); step();  // sub $5
      drive_a(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0);
      n_checks++; if (bus_a.registerRsForwardControl !== 2'd1) $display("FAIL youngest_rsfwd: got %0d expected 1", bus_a.registerRsForwardControl); else n_pass++;
      step();
      idle_all();
   endtask

   task automatic test_reg0_flush();
      pulse_reset();
      drive_a(1, 5'd1, 1, 5'd0, 0, 1, 5'd0, 1, 0); step();  // lw $0
      drive_a(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0);
      n_checks++; if (bus_a.shouldStall !== 1'b0) $display("FAIL r0_stall: got %0b expected 0", bus_a.shouldStall); else n_pass++;
      n_checks++; if (bus_a.registerRsForwardControl !== 2'd0) $display("FAIL r0_rsfwd: got %0d expected 0", bus_a.registerRsForwardControl); else n_pass++;
      n_checks++; if (bus_a.registerRtForwardControl !== 2'd0) $display("FAIL r0_rtfwd: got %0d expected 0", bus_a.registerRtForwardControl); else n_pass++;
      step();
      drive_a(1, 5'd1, 1, 5'd0, 0, 1, 5'd6, 1, 0); step();  // lw $6
      // Flushed reader of $6 that would itself write $6 if not squashed.
      drive_a(1, 5'd6, 1, 5'd0, 0, 1, 5'd6, 0, 1);
      n_checks++; if (bus_a.shouldStall !== 1'b0) $display("FAIL flush_stall: got %0b expected 0", bus_a.shouldStall); else n_pass++;
      step();
      drive_a(1, 5'd6, 1, 5'd0, 0, 0, 5'd0, 0, 0);
      n_checks++; if (bus_a.registerRsForwardControl !== 2'd2) $display("FAIL flush_bubble_rsfwd: got %0d expected 2", bus_a.registerRsForwardControl); else n_pass++;
      n_checks++; if (bus_a.stallCount !== 16'd0) $display("FAIL flush_count: got %0d expected 0", bus_a.stallCount); else n_pass++;
      // Invalid decode never stalls or forwards, even on a pending load.
      drive_a(1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 1, 0); step();  // lw $7
      drive_a(0, 5'd7, 1, 5'd7, 1, 0, 5'd0, 0, 0);
      n_checks++; if (bus_a.shouldStall !== 1'b0) $display("FAIL invalid_stall: got %0b expected 0", bus_a.shouldStall); else n_pass++;
      n_checks++; if (bus_a.registerRsForwardControl !== 2'd0) $display("FAIL invalid_rsfwd: got %0d expected 0", bus_a.registerRsForwardControl); else n_pass++;
      step();
      idle_all();
   endtask

   task automatic test_param();
      pulse_reset();
      drive_b(1, 5'd1, 1, 1, 5'd7, 1); step();             // lw $7
      drive_b(1, 5'd7, 1, 0, 5'd0, 0);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (bus_b.shouldStall !== 1'b1) $display("FAIL param_stall%0d: got %0b expected 1", i, bus_b.shouldStall); else n_pass++;
         step();
      end
      n_checks++; if (bus_b.shouldStall !== 1'b0) $display("FAIL param_stall_end: got %0b expected 0", bus_b.shouldStall); else n_pass++;
      n_checks++; if (bus_b.registerRsForwardControl !== 3'd4) $display("FAIL param_rsfwd: got %0d expected 4", bus_b.registerRsForwardControl); else n_pass++;
      n_checks++; if (bus_b.stallCount !== 16'd3) $display("FAIL param_count: got %0d expected 3", bus_b.stallCount); else n_pass++;
      step();
      drive_b(1, 5'd1, 1, 1, 5'd10, 0); step();            // add $10
      drive_b(0, 5'd0, 0, 0, 5'd0, 0);
      for (int i = 0; i < 4; i++) step();
      drive_b(1, 5'd10, 1, 0, 5'd0, 0);
      n_checks++; if (bus_b.registerRsForwardControl !== 3'd5) $display("FAIL param_rsfwd_last: got %0d expected 5", bus_b.registerRsForwardControl); else n_pass++;
      drive_b(0, 5'd0, 0, 0, 5'd0, 0);
      step();
      drive_b(1, 5'd10, 1, 0, 5'd0, 0);
      n_checks++; if (bus_b.registerRsForwardControl !== 3'd0) $display("FAIL param_retired: got %0d expected 0", bus_b.registerRsForwardControl); else n_pass++;
      step();
      idle_all();
   endtask

   task automatic test_saturation();
      pulse_reset();
      // lw $1,0($1) repeatedly: each issue blocks the next for 6 cycles.
      bus_c.decodeValid = 1'b1; bus_c.decodeRs = 5'd1; bus_c.decodeUsesRs = 1'b1;
      bus_c.decodeWritesRegister = 1'b1; bus_c.decodeWriteRegister = 5'd1;
      bus_c.decodeIsLoad = 1'b1;
      #1;
      for (int i = 0; i < 77000; i++) @(posedge clk);
      #1;
      n_checks++; if (bus_c.stallCount !== 16'hFFFF) $display("FAIL sat_count: got %0h expected ffff", bus_c.stallCount); else n_pass++;
      pulse_reset();
      n_checks++; if (bus_c.stallCount !== 16'd0) $display("FAIL sat_reset_count: got %0d expected 0", bus_c.stallCount); else n_pass++;
      n_checks++; if (bus_c.shouldStall !== 1'b0) $display("FAIL sat_reset_stall: got %0b expected 0", bus_c.shouldStall); else n_pass++;
      idle_all();
   endtask

   // Sequencer and final report
   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      idle_all();
      step();
      test_reset();
      test_alu_back_to_back();
      test_load_use();
      test_youngest();
      test_reg0_flush();
      test_param();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
